// File: rtl/friscv_uc.sv
// Dispenser control unit: periodic cup sensing with confirmation, timed pump
// fill with cancel-on-loss, and a cup-removal wait before re-arming.
module friscv_uc #(
  parameter int INTERVALO_MEDIDA = 5_000_000,
  parameter int TIMEOUT_MEDIDA   = 2_000_000,
  parameter int TEMPO_ENCHE      = 150_000_000,
  parameter int CONFIRMACOES     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_medida,
  input  logic       copo_posicionado,
  output logic       inicia_medida,
  output logic       bomba,
  output logic       pronto,
  output logic       cancelado,
  output logic [3:0] db_estado
);

  // Datapath handshake: inicia_medida is a one-cycle request; the datapath
  // answers later with a one-cycle fim_medida, and copo_posicionado is only
  // meaningful in that cycle. fim_medida outside AGUARDA is dropped.

  localparam int CNT_MAX = (INTERVALO_MEDIDA > TIMEOUT_MEDIDA) ? INTERVALO_MEDIDA : TIMEOUT_MEDIDA;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ENCHE_W = (TEMPO_ENCHE > 1) ? $clog2(TEMPO_ENCHE) : 1;
  localparam int CONF_W  = $clog2(CONFIRMACOES + 1);

  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_MEDIDA - 1);
  localparam logic [CNT_W-1:0]   IV_LAST   = CNT_W'(INTERVALO_MEDIDA - 1);
  localparam logic [ENCHE_W-1:0] EN_LAST   = ENCHE_W'(TEMPO_ENCHE - 1);
  localparam logic [CONF_W-1:0]  CONF_FULL = CONF_W'(CONFIRMACOES);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    MEDE      = 4'd2,
    AGUARDA   = 4'd3,
    AVALIA    = 4'd4,
    INTERVALO = 4'd5
  } estado_t;

  typedef enum logic [1:0] {
    DETECCAO   = 2'd0,
    ENCHIMENTO = 2'd1,
    RETIRADA   = 2'd2
  } modo_t;

  estado_t             estado;
  modo_t               modo;
  logic                amostra;
  logic [CONF_W-1:0]   conf;
  logic [CNT_W-1:0]    cnt;
  logic [ENCHE_W-1:0]  cnt_enche;
  logic [CONF_W-1:0]   conf_inc;

  assign conf_inc  = conf + 1'b1;
  assign db_estado = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= INICIAL;
      modo          <= DETECCAO;
      amostra       <= 1'b0;
      conf          <= '0;
      cnt           <= '0;
      cnt_enche     <= '0;
      inicia_medida <= 1'b0;
      bomba         <= 1'b0;
      pronto        <= 1'b0;
      cancelado     <= 1'b0;
    end else begin
      inicia_medida <= 1'b0;
      pronto        <= 1'b0;
      cancelado     <= 1'b0;
      if (!ligar && estado != INICIAL) begin
        estado    <= INICIAL;
        modo      <= DETECCAO;
        amostra   <= 1'b0;
        conf      <= '0;
        cnt       <= '0;
        cnt_enche <= '0;
        bomba     <= 1'b0;
      end else begin
        case (estado)
          INICIAL: if (ligar) estado <= PREPARA;
          PREPARA: begin
            conf          <= '0;
            cnt           <= '0;
            cnt_enche     <= '0;
            modo          <= DETECCAO;
            bomba         <= 1'b0;
            estado        <= MEDE;
            inicia_medida <= 1'b1;
          end
          MEDE: begin
            cnt    <= '0;
            estado <= AGUARDA;
          end
          AGUARDA: begin
            if (fim_medida) begin
              amostra <= copo_posicionado;
              estado  <= AVALIA;
            end else if (cnt == TO_LAST) begin
              amostra <= 1'b0;
              estado  <= AVALIA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          AVALIA: begin
            cnt    <= '0;
            estado <= INTERVALO;
            case (modo)
              DETECCAO: begin
                if (!amostra) begin
                  conf <= '0;
                end else if (conf_inc == CONF_FULL) begin
                  conf      <= '0;
                  bomba     <= 1'b1;
                  cnt_enche <= '0;
                  modo      <= ENCHIMENTO;
                end else begin
                  conf <= conf_inc;
                end
              end
              ENCHIMENTO: begin
                if (!amostra) begin
                  bomba     <= 1'b0;
                  cancelado <= 1'b1;
                  modo      <= DETECCAO;
                  conf      <= '0;
                end
              end
              RETIRADA: begin
                if (!amostra) begin
                  modo <= DETECCAO;
                  conf <= '0;
                end
              end
              default: modo <= DETECCAO;
            endcase
          end
          INTERVALO: begin
            if (cnt == IV_LAST) begin
              estado        <= MEDE;
              inicia_medida <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: estado <= INICIAL;
        endcase

        // Fill timer runs regardless of state; placed last so completion
        // overrides a cancel decided in AVALIA during the same cycle.
        if (bomba) begin
          if (cnt_enche == EN_LAST) begin
            bomba     <= 1'b0;
            pronto    <= 1'b1;
            cancelado <= 1'b0;
            modo      <= RETIRADA;
            cnt_enche <= '0;
          end else begin
            cnt_enche <= cnt_enche + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_friscv_uc.sv
// Directed bench for friscv_uc: table of measurement results with expected
// pump/cancel outcomes, plus hand sequences for timeout, reset and disable.
module tb_friscv_uc;

  localparam int IV = 10;
  localparam int TO = 20;
  localparam int EN = 100;
  localparam int CF = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ligar = 1'b0;
  logic       fim_medida = 1'b0;
  logic       copo_posicionado = 1'b0;
  logic       inicia_medida;
  logic       bomba;
  logic       pronto;
  logic       cancelado;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // scoreboard of expected output pulses: 2'b10 = pronto, 2'b01 = cancelado
  logic [1:0] exp_q[$];

  int  run_len  = 0;
  int  last_len = 0;
  logic prev_bomba = 1'b0;

  friscv_uc #(
    .INTERVALO_MEDIDA(IV),
    .TIMEOUT_MEDIDA  (TO),
    .TEMPO_ENCHE     (EN),
    .CONFIRMACOES    (CF)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ligar           (ligar),
    .fim_medida      (fim_medida),
    .copo_posicionado(copo_posicionado),
    .inicia_medida   (inicia_medida),
    .bomba           (bomba),
    .pronto          (pronto),
    .cancelado       (cancelado),
    .db_estado       (db_estado)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // monitor: pulse scoreboard, pump run length, pronto alignment
  always @(negedge clock) begin
    if (pronto || cancelado) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: got pronto=%0b cancelado=%0b, expected no pulse (cycle %0d)",
                 pronto, cancelado, cyc);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({pronto, cancelado} != e) begin
          errors++;
          $display("FAIL event: got %b, expected %b (cycle %0d)", {pronto, cancelado}, e, cyc);
        end
      end
    end
    if (pronto) begin
      checks++;
      if (bomba || !prev_bomba) begin
        errors++;
        $display("FAIL pronto_align: got bomba=%0b prev=%0b, expected bomba=0 prev=1", bomba, prev_bomba);
      end
    end
    if (bomba) run_len++;
    else if (prev_bomba) begin
      last_len = run_len;
      run_len  = 0;
    end
    prev_bomba = bomba;
  end

  // driver tasks
  task automatic wait_trig(output int trig);
    int n;
    n = 0;
    while (!inicia_medida && n < 200) begin
      tick();
      n++;
    end
    chk("trigger_wait", int'(inicia_medida), 1);
    trig = cyc;
  endtask

  // Answers dly cycles after the trigger, then returns in the cycle right
  // after AVALIA, where the evaluation's outputs are visible.
  task automatic measure(input logic copo_v, input int dly, output int trig);
    wait_trig(trig);
    repeat (dly) tick();
    fim_medida       = 1'b1;
    copo_posicionado = copo_v;
    tick();
    fim_medida       = 1'b0;
    copo_posicionado = 1'b0;
    tick();
  endtask

  typedef struct {
    logic copo;
    logic exp_bomba;
    logic exp_cancel;
    logic exp_pronto;
  } vec_t;

  vec_t vecs[25];

  initial begin
    int t_prev, t_cur, ta, tb, tc, td;

    vecs = '{
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 1
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 2
      '{1'b0, 1'b0, 1'b0, 1'b0},  // 3 negative clears confirmations
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 4
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 5
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 6 third consecutive: fill starts
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 7
      '{1'b0, 1'b0, 1'b1, 1'b0},  // 8 cup lost: cancel
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 9
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 10
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 11 refill
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 12
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 13
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 14
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 15
      '{1'b1, 1'b1, 1'b0, 1'b0},  // 16
      '{1'b1, 1'b0, 1'b0, 1'b1},  // 17 fill completes during this one
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 18 cup still present: wait removal
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 19
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 20
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 21
      '{1'b0, 1'b0, 1'b0, 1'b0},  // 22 removed: re-arm
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 23
      '{1'b1, 1'b0, 1'b0, 1'b0},  // 24
      '{1'b1, 1'b1, 1'b0, 1'b0}   // 25 new fill
    };

    repeat (3) tick();
    chk("rst_inicia", int'(inicia_medida), 0);
    chk("rst_bomba", int'(bomba), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_cancelado", int'(cancelado), 0);
    chk("rst_estado", int'(db_estado), 0);
    reset = 1'b0;
    tick();
    chk("idle_estado", int'(db_estado), 0);

    ligar = 1'b1;
    tick();
    chk("prep_estado", int'(db_estado), 1);
    chk("prep_inicia", int'(inicia_medida), 0);
    tick();
    chk("mede_inicia", int'(inicia_medida), 1);
    chk("mede_estado", int'(db_estado), 2);

    t_prev = 0;
    for (int i = 0; i < 25; i++) begin
      if (vecs[i].exp_cancel) exp_q.push_back(2'b01);
      if (vecs[i].exp_pronto) exp_q.push_back(2'b10);
      measure(vecs[i].copo, 5, t_cur);
      chk($sformatf("vec%0d_bomba", i + 1), int'(bomba), int'(vecs[i].exp_bomba));
      chk($sformatf("vec%0d_cancelado", i + 1), int'(cancelado), int'(vecs[i].exp_cancel));
      if (i > 0) chk($sformatf("vec%0d_period", i + 1), t_cur - t_prev, IV + 3 + 4);
      if (vecs[i].exp_pronto) chk("fill_len", last_len, EN);
      t_prev = t_cur;
    end

    // disable during a fill: immediate idle, no pronto later
    ligar = 1'b0;
    tick();
    chk("off_estado", int'(db_estado), 0);
    chk("off_bomba", int'(bomba), 0);
    repeat (120) tick();
    chk("off_stays_idle", int'(db_estado), 0);

    // instant answers, then a timeout counted as a negative
    ligar = 1'b1;
    measure(1'b1, 1, ta);
    measure(1'b1, 1, tb);
    chk("instant_period", tb - ta, IV + 3);
    chk("instant_bomba", int'(bomba), 0);
    wait_trig(tc);
    chk("instant_period2", tc - tb, IV + 3);
    repeat (TO) tick();
    chk("aguarda_last", int'(db_estado), 3);
    tick();
    chk("timeout_avalia", int'(db_estado), 4);
    fim_medida       = 1'b1;
    copo_posicionado = 1'b1;
    tick();
    fim_medida       = 1'b0;
    copo_posicionado = 1'b0;
    chk("late_fim_intervalo", int'(db_estado), 5);
    measure(1'b1, 5, td);
    chk("timeout_period", td - tc, IV + TO + 2);
    chk("after_timeout_bomba1", int'(bomba), 0);
    measure(1'b1, 5, td);
    chk("after_timeout_bomba2", int'(bomba), 0);
    measure(1'b1, 5, td);
    chk("after_timeout_bomba3", int'(bomba), 1);

    // asynchronous reset mid-fill
    tick();
    chk("pre_rst_bomba", int'(bomba), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_bomba", int'(bomba), 0);
    chk("async_rst_estado", int'(db_estado), 0);
    chk("async_rst_inicia", int'(inicia_medida), 0);
    ligar = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_estado", int'(db_estado), 0);
    ligar = 1'b1;
    tick();
    chk("post_rst_prep", int'(inicia_medida), 0);
    tick();
    chk("post_rst_inicia", int'(inicia_medida), 1);

    // disable while waiting for the datapath
    tick();
    chk("aguarda_entry", int'(db_estado), 3);
    ligar = 1'b0;
    tick();
    chk("off_aguarda_estado", int'(db_estado), 0);
    chk("off_aguarda_inicia", int'(inicia_medida), 0);
    repeat (5) tick();

    chk("events_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
